axi_slave_mem_responder: RTL

AXI_SLAVE_MEM_RESPONDER -- requirements
Module: axi_slave_mem_responder

---
 rtl/axi_slave_mem_responder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_slave_mem_responder.sv
// AXI4 slave backed by a 32-bit word memory; independent write (AW/W/B) and read (AR/R) FSMs.
// Define AXI_SLV_OOR_ERR_EN to answer out-of-range word addresses with SLVERR instead of wrapping.
module axi_slave_mem_responder #(
  parameter int unsigned ID_WIDTH  = 4,
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_WIDTH-1:0] S_AWID,
  input  logic [31:0]         S_AWADDR,
  input  logic [3:0]          S_AWLEN,
  input  logic [1:0]          S_AWBURST,
  input  logic                S_AWVALID,
  output logic                S_AWREADY,
  input  logic [31:0]         S_WDATA,
  input  logic [3:0]          S_WSTRB,
  input  logic                S_WLAST,
  input  logic                S_WVALID,
  output logic                S_WREADY,
  output logic [ID_WIDTH-1:0] S_BID,
  output logic [1:0]          S_BRESP,
  output logic                S_BVALID,
  input  logic                S_BREADY,
  input  logic [ID_WIDTH-1:0] S_ARID,
  input  logic [31:0]         S_ARADDR,
  input  logic [3:0]          S_ARLEN,
  input  logic [1:0]          S_ARBURST,
  input  logic                S_ARVALID,
  output logic                S_ARREADY,
  output logic [ID_WIDTH-1:0] S_RID,
  output logic [31:0]         S_RDATA,
  output logic [1:0]          S_RRESP,
  output logic                S_RLAST,
  output logic                S_RVALID,
  input  logic                S_RREADY
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);
`ifdef AXI_SLV_OOR_ERR_EN
  localparam bit OorErrEn = 1'b1;
`else
  localparam bit OorErrEn = 1'b0;
`endif
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] BurstIncr  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  logic [31:0] mem [MEM_WORDS];

  w_state_e            w_state_q, w_state_d;
  logic [ID_WIDTH-1:0] aw_id_q;
  logic [29:0]         aw_addr_q;
  logic [3:0]          aw_len_q;
  logic [1:0]          aw_burst_q;
  logic [4:0]          w_cnt_q;
  logic                w_err_q;
  logic [1:0]          b_resp_q;
  logic                aw_hs, w_hs, w_oor, w_burst_bad, w_len_bad, w_we;

  r_state_e            r_state_q, r_state_d;
  logic [ID_WIDTH-1:0] ar_id_q;
  logic [29:0]         r_addr_q, r_fetch_addr;
  logic [3:0]          r_len_q, r_cnt_q;
  logic [1:0]          r_burst_q, r_fetch_burst, r_resp_q;
  logic [31:0]         r_data_q;
  logic                r_last_q, ar_hs, r_hs, r_load, r_fetch_bad;

  logic unused_addr;
  assign unused_addr = ^{S_AWADDR[1:0], S_ARADDR[1:0]};

  // Ready outputs are masked while reset is held so nothing is accepted mid-reset.
  always_comb begin
    w_state_d = w_state_q;
    S_AWREADY = 1'b0;
    S_WREADY  = 1'b0;
    S_BVALID  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        S_AWREADY = !ARESET;
        if (S_AWVALID) w_state_d = W_DATA;
      end
      W_DATA: begin
        S_WREADY = !ARESET;
        if (S_WVALID && S_WLAST) w_state_d = W_RESP;
      end
      W_RESP: begin
        S_BVALID = 1'b1;
        if (S_BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign aw_hs       = S_AWVALID && S_AWREADY;
  assign w_hs        = S_WVALID && S_WREADY;
  assign w_burst_bad = aw_burst_q[1];
  assign w_oor       = OorErrEn && (aw_addr_q >= 30'(MEM_WORDS));
  assign w_len_bad   = (w_cnt_q != {1'b0, aw_len_q});
  assign w_we        = w_hs && !w_burst_bad && !w_oor;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
      b_resp_q   <= RespOkay;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        aw_id_q    <= S_AWID;
        aw_addr_q  <= S_AWADDR[31:2];
        aw_len_q   <= S_AWLEN;
        aw_burst_q <= S_AWBURST;
        w_cnt_q    <= '0;
        w_err_q    <= 1'b0;
      end
      if (w_hs) begin
        if (aw_burst_q == BurstIncr) aw_addr_q <= aw_addr_q + 30'd1;
        // Saturating count keeps over-long bursts flagged as a length mismatch.
        if (w_cnt_q != 5'h1f) w_cnt_q <= w_cnt_q + 5'd1;
        if (w_oor) w_err_q <= 1'b1;
        if (S_WLAST) begin
          b_resp_q <= (w_burst_bad || w_len_bad || w_oor || w_err_q) ? RespSlvErr : RespOkay;
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (S_WSTRB[b]) mem[aw_addr_q[IdxW-1:0]][8*b +: 8] <= S_WDATA[8*b +: 8];
      end
    end
  end

  assign S_BID   = aw_id_q;
  assign S_BRESP = b_resp_q;

  always_comb begin
    r_state_d = r_state_q;
    S_ARREADY = 1'b0;
    S_RVALID  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        S_ARREADY = !ARESET;
        if (S_ARVALID) r_state_d = R_DATA;
      end
      R_DATA: begin
        S_RVALID = 1'b1;
        if (S_RREADY && r_last_q) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign ar_hs  = S_ARVALID && S_ARREADY;
  assign r_hs   = S_RVALID && S_RREADY;
  assign r_load = ar_hs || (r_hs && !r_last_q);

  // Address of the beat to present next: beat 0 from AR, later beats from the running address.
  always_comb begin
    r_fetch_addr  = S_ARADDR[31:2];
    r_fetch_burst = S_ARBURST;
    if (r_state_q == R_DATA) begin
      r_fetch_addr  = (r_burst_q == BurstIncr) ? r_addr_q + 30'd1 : r_addr_q;
      r_fetch_burst = r_burst_q;
    end
  end

  assign r_fetch_bad = r_fetch_burst[1] || (OorErrEn && (r_fetch_addr >= 30'(MEM_WORDS)));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      ar_id_q   <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      r_data_q  <= '0;
      r_resp_q  <= RespOkay;
      r_last_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        ar_id_q   <= S_ARID;
        r_len_q   <= S_ARLEN;
        r_burst_q <= S_ARBURST;
        r_cnt_q   <= '0;
        r_last_q  <= (S_ARLEN == 4'd0);
      end else if (r_hs && !r_last_q) begin
        r_cnt_q  <= r_cnt_q + 4'd1;
        r_last_q <= ((r_cnt_q + 4'd1) == r_len_q);
      end
      if (r_load) begin
        r_addr_q <= r_fetch_addr;
        r_data_q <= r_fetch_bad ? '0 : mem[r_fetch_addr[IdxW-1:0]];
        r_resp_q <= r_fetch_bad ? RespSlvErr : RespOkay;
      end
    end
  end

  assign S_RID   = ar_id_q;
  assign S_RDATA = r_data_q;
  assign S_RRESP = r_resp_q;
  assign S_RLAST = r_last_q;

endmodule
